// File: rtl/accum_delta_decoder.sv
// accum_delta_decoder: recovers 4-bit increments from an 8-bit running-sum stream
// and buffers them in a show-ahead FIFO drained over valid/ready.
// Optional ACCUM_DELTA_STATS_EN adds saturating push/error counters.
module accum_delta_decoder #(
    parameter int          DEPTH         = 4,
    parameter logic [7:0]  INIT_SUM      = 8'h00,
    parameter bit          SYNC_ON_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               sum_in,
    input  logic                     sum_valid,
    input  logic                     resync,
    output logic [3:0]               delta_out,
    output logic                     delta_valid,
    input  logic                     delta_ready,
    output logic                     range_err,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fill
`ifdef ACCUM_DELTA_STATS_EN
    ,
    output logic [15:0]              stat_deltas,
    output logic [15:0]              stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_BASE,
        ST_TRACK
    } state_t;

    // State the decoder returns to after reset or resync
    localparam state_t ST_INIT = SYNC_ON_FIRST ? ST_BASE : ST_TRACK;

    state_t          state;
    logic [7:0]      prev;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [7:0]      diff;
    logic            legal;
    logic            track_sample;
    logic            push_req;
    logic            full;
    logic            pop;
    logic            push;

    // resync wins over a coincident sample, so the sample is simply ignored
    assign diff         = sum_in - prev;
    assign legal        = (diff[7:4] == 4'h0);
    assign track_sample = sum_valid && !resync && (state == ST_TRACK);
    assign push_req     = track_sample && legal;
    assign full         = (count == FULL_CNT);
    assign pop          = (count != '0) && delta_ready;
    // A pop in the same cycle frees the slot the push needs
    assign push         = push_req && (!full || pop);

    assign delta_valid  = (count != '0);
    assign delta_out    = delta_valid ? mem[rd_ptr] : 4'h0;
    assign fill         = count;

    // Baseline tracking FSM: BASE swallows one sample, TRACK diffs every sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            prev  <= INIT_SUM;
        end else if (resync) begin
            state <= ST_INIT;
            prev  <= INIT_SUM;
        end else if (sum_valid) begin
            state <= ST_TRACK;
            prev  <= sum_in;
        end
    end

    // FIFO storage; contents are don't-care outside the live window
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= diff[3:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (resync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags: one-cycle range pulse, sticky overflow on a dropped delta
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
            ovf       <= 1'b0;
        end else if (resync) begin
            range_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            range_err <= track_sample && !legal;
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef ACCUM_DELTA_STATS_EN
    // Saturating counters of pushed deltas and range errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_deltas <= '0;
            stat_errs   <= '0;
        end else if (resync) begin
            stat_deltas <= '0;
            stat_errs   <= '0;
        end else begin
            if (push && (stat_deltas != 16'hFFFF)) begin
                stat_deltas <= stat_deltas + 16'd1;
            end
            if (track_sample && !legal && (stat_errs != 16'hFFFF)) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accum_delta_decoder.sv
// Self-checking bench for accum_delta_decoder: scoreboard of expected deltas
// for the SYNC_ON_FIRST=0 instance, direct checks for the SYNC_ON_FIRST=1 one.
module tb_accum_delta_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sum_in;
    logic        sum_valid;
    logic        resync;
    logic [3:0]  delta_out;
    logic        delta_valid;
    logic        ready;
    logic        range_err;
    logic        ovf;
    logic [2:0]  fill;

    logic [7:0]  s_sum_in;
    logic        s_sum_valid;
    logic        s_resync;
    logic [3:0]  s_delta_out;
    logic        s_delta_valid;
    logic        s_ready;
    logic        s_range_err;
    logic        s_ovf;
    logic [2:0]  s_fill;

`ifdef ACCUM_DELTA_STATS_EN
    logic [15:0] stat_deltas, stat_errs, s_stat_deltas, s_stat_errs;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  q[$];
    logic [7:0]  model_prev;

    always #5 clk = ~clk;

    accum_delta_decoder #(.DEPTH(4), .INIT_SUM(8'h00), .SYNC_ON_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .resync(resync),
        .delta_out(delta_out), .delta_valid(delta_valid), .delta_ready(ready),
        .range_err(range_err), .ovf(ovf), .fill(fill)
`ifdef ACCUM_DELTA_STATS_EN
        , .stat_deltas(stat_deltas), .stat_errs(stat_errs)
`endif
    );

    accum_delta_decoder #(.DEPTH(4), .INIT_SUM(8'h00), .SYNC_ON_FIRST(1'b1)) dut_s (
        .clk(clk), .rst(rst), .sum_in(s_sum_in), .sum_valid(s_sum_valid), .resync(s_resync),
        .delta_out(s_delta_out), .delta_valid(s_delta_valid), .delta_ready(s_ready),
        .range_err(s_range_err), .ovf(s_ovf), .fill(s_fill)
`ifdef ACCUM_DELTA_STATS_EN
        , .stat_deltas(s_stat_deltas), .stat_errs(s_stat_errs)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample to dut; expected delta goes to the scoreboard unless dropped
    task automatic send(input logic [7:0] s, input bit drop);
        logic [7:0] d;
        d = s - model_prev;
        model_prev = s;
        if (d <= 8'd15 && !drop) q.push_back(d[3:0]);
        sum_in = s;
        sum_valid = 1'b1;
        @(posedge clk); #1;
        sum_valid = 1'b0;
        check("range_err", range_err, (d > 8'd15) ? 1 : 0);
    endtask

    task automatic s_send(input logic [7:0] s);
        s_sum_in = s;
        s_sum_valid = 1'b1;
        @(posedge clk); #1;
        s_sum_valid = 1'b0;
    endtask

    task automatic resync_pulse();
        resync = 1'b1;
        @(posedge clk); #1;
        resync = 1'b0;
        model_prev = 8'h00;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && fill != 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check({tag, "_fill0"}, fill, 0);
        check({tag, "_sb_empty"}, q.size(), 0);
    endtask

    // Scoreboard compare: a handshake seen at negedge completes at the next posedge
    always @(negedge clk) begin
        if (!rst && delta_valid && ready) begin
            if (q.size() == 0) check("sb_extra", q.size(), 1);
            else               check("delta", delta_out, q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sum_in = 8'h00; sum_valid = 1'b0; resync = 1'b0; ready = 1'b0;
        s_sum_in = 8'h00; s_sum_valid = 1'b0; s_resync = 1'b0; s_ready = 1'b0;
        model_prev = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_valid", delta_valid, 0);
        check("rst_fill", fill, 0);
        check("rst_ovf", ovf, 0);
        check("rst_range", range_err, 0);
        check("rst_dout", delta_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic deltas 3,5,0,F, one cycle latency
        ready = 1'b1;
        send(8'h03, 0); check("t1_lat0", delta_valid, 1); check("t1_dout0", delta_out, 3);
        send(8'h08, 0); check("t1_lat1", delta_valid, 1);
        send(8'h08, 0); check("t1_lat2", delta_valid, 1);
        send(8'h17, 0); check("t1_lat3", delta_valid, 1);
        drain("t1");

        // 2: range error FE, wrap FE->02, range error 02->22, then 25
        send(8'hFE, 0);
        send(8'h02, 0);
        send(8'h22, 0);
        @(posedge clk); #1;
        check("t2_pulse_end", range_err, 0);
        send(8'h25, 0);
        drain("t2");
`ifdef ACCUM_DELTA_STATS_EN
        check("t2_stat_deltas", stat_deltas, 6);
        check("t2_stat_errs", stat_errs, 2);
`endif

        // 3: fill with ready low, fifth delta dropped
        resync_pulse();
        ready = 1'b0;
        send(8'h01, 0); send(8'h03, 0); send(8'h06, 0); send(8'h0A, 0);
        check("t3_ovf_pre", ovf, 0);
        send(8'h0F, 1);
        check("t3_fill", fill, 4);
        check("t3_ovf", ovf, 1);
        check("t3_head", delta_out, 1);
`ifdef ACCUM_DELTA_STATS_EN
        check("t3_stat_deltas", stat_deltas, 4);
`endif
        ready = 1'b1;
        drain("t3");
        check("t3_ovf_sticky", ovf, 1);

        // 4: full FIFO with simultaneous push and pop
        resync_pulse();
        check("t4_ovf_clr", ovf, 0);
        ready = 1'b0;
        send(8'h02, 0); send(8'h05, 0); send(8'h09, 0); send(8'h0E, 0);
        check("t4_fill_full", fill, 4);
        ready = 1'b1;
        send(8'h0F, 0);
        check("t4_fill_same", fill, 4);
        check("t4_ovf", ovf, 0);
        drain("t4");

        // 5: SYNC_ON_FIRST instance: baseline sample, resync mid-stream
        s_send(8'h40);
        check("t5_base_fill", s_fill, 0);
        check("t5_base_valid", s_delta_valid, 0);
        s_send(8'h43);
        check("t5_fill1", s_fill, 1);
        check("t5_dout", s_delta_out, 3);
        s_send(8'h45);
        check("t5_fill2", s_fill, 2);
        s_resync = 1'b1;
        @(posedge clk); #1;
        s_resync = 1'b0;
        check("t5_rs_fill", s_fill, 0);
        check("t5_rs_valid", s_delta_valid, 0);
        check("t5_rs_ovf", s_ovf, 0);
        s_send(8'h80);
        check("t5_rebase_fill", s_fill, 0);
        s_send(8'h81);
        check("t5_after_fill", s_fill, 1);
        check("t5_after_dout", s_delta_out, 1);

        // 6: asynchronous reset between edges with data buffered
        ready = 1'b0;
        send(8'h12, 0); send(8'h14, 0);
        check("t6_fill_pre", fill, 2);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_valid", delta_valid, 0);
        check("t6_fill", fill, 0);
        check("t6_dout", delta_out, 0);
        check("t6_ovf", ovf, 0);
        check("t6_s_fill", s_fill, 0);
`ifdef ACCUM_DELTA_STATS_EN
        check("t6_stat_deltas", stat_deltas, 0);
        check("t6_stat_errs", stat_errs, 0);
`endif
        q.delete();
        model_prev = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        send(8'h07, 0);
        check("t6_post_valid", delta_valid, 1);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
